// File: rtl/clkdiv_prog_mc.sv
// Multi-channel programmable clock divider: per-channel period (div+1) and high time,
// settings reloaded only at period wrap or global sync, registered out and tick.
module clkdiv_prog_mc #(
  parameter int N  = 4,
  parameter int CH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   en_i,
  input  logic            sync_i,
  input  logic [CH*N-1:0] div_i,
  input  logic [CH*N-1:0] hi_i,
  output logic [CH-1:0]   out_o,
  output logic [CH-1:0]   tick_o
);

  logic [CH-1:0][N-1:0] cnt_q, cnt_d;
  logic [CH-1:0][N-1:0] div_s_q, div_s_d;
  logic [CH-1:0][N-1:0] hi_s_q, hi_s_d;
  logic [CH-1:0]        out_q, out_d;
  logic [CH-1:0]        tick_q, tick_d;

  always_comb begin
    cnt_d   = cnt_q;
    div_s_d = div_s_q;
    hi_s_d  = hi_s_q;
    tick_d  = '0;
    out_d   = '0;
    for (int c = 0; c < CH; c++) begin
      if (!en_i[c]) begin
        // Parking cnt at the new div guarantees the first enabled edge wraps.
        div_s_d[c] = div_i[c*N +: N];
        hi_s_d[c]  = hi_i[c*N +: N];
        cnt_d[c]   = div_i[c*N +: N];
        tick_d[c]  = 1'b0;
        out_d[c]   = 1'b0;
      end else begin
        if (sync_i || (cnt_q[c] == div_s_q[c])) begin
          cnt_d[c]   = '0;
          div_s_d[c] = div_i[c*N +: N];
          hi_s_d[c]  = hi_i[c*N +: N];
          tick_d[c]  = 1'b1;
        end else begin
          cnt_d[c]   = cnt_q[c] + 1'b1;
          tick_d[c]  = 1'b0;
        end
        out_d[c] = (cnt_d[c] < hi_s_d[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_s_q <= '0;
      hi_s_q  <= '0;
      out_q   <= '0;
      tick_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_s_q <= div_s_d;
      hi_s_q  <= hi_s_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_clkdiv_prog_mc.sv
// Bench for clkdiv_prog_mc: period/phase model checked every cycle plus literal waveforms.
module tb_clkdiv_prog_mc;
  localparam int N  = 4;
  localparam int CH = 2;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   en;
  logic            sync;
  logic [CH*N-1:0] div;
  logic [CH*N-1:0] hi;
  logic [CH-1:0]   out_o;
  logic [CH-1:0]   tick_o;

  int tests = 0;
  int fails = 0;

  clkdiv_prog_mc #(.N(N), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sync_i(sync),
    .div_i(div), .hi_i(hi), .out_o(out_o), .tick_o(tick_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each channel is a position inside a period of length div+1 with settings
  // captured when the period starts; a disabled channel always starts fresh.
  int pos [CH];
  int per [CH];
  int hv  [CH];
  bit fresh [CH];
  logic [CH-1:0] m_out, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        fresh[c] = 1'b1; pos[c] = 0; per[c] = 1; hv[c] = 0;
      end
      m_out = '0; m_tick = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (!en[c]) begin
          fresh[c] = 1'b1; m_out[c] = 1'b0; m_tick[c] = 1'b0;
        end else begin
          if (sync || fresh[c] || (pos[c] + 1 >= per[c])) begin
            pos[c] = 0;
            per[c] = int'(div[c*N +: N]) + 1;
            hv[c]  = int'(hi[c*N +: N]);
            fresh[c] = 1'b0;
            m_tick[c] = 1'b1;
          end else begin
            pos[c] = pos[c] + 1;
            m_tick[c] = 1'b0;
          end
          m_out[c] = (pos[c] < hv[c]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_out", 32'(out_o), 32'(m_out));
      chk("model_tick", 32'(tick_o), 32'(m_tick));
    end
  end

  logic [31:0] co, ct;

  task automatic set_ch(input int c, input int d, input int h);
    div[c*N +: N] = N'(d);
    hi[c*N +: N]  = N'(h);
  endtask

  task automatic cap(input int k, input int c);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      co = {co[30:0], out_o[c]};
      ct = {ct[30:0], tick_o[c]};
    end
  endtask

  task automatic restart_ch0(input int d, input int h);
    en[0] = 1'b0;
    @(negedge clk);
    set_ch(0, d, h);
    en[0] = 1'b1;
    co = '0; ct = '0;
  endtask

  initial begin
    int first;
    logic [3:0] dis_out;
    rst_n = 1'b1; en = '0; sync = 1'b0; div = '0; hi = '0;
    #1 rst_n = 1'b0;
    set_ch(0, 3, 0); set_ch(1, 3, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_out", 32'(out_o), 32'h0);
    chk("idle_tick", 32'(tick_o), 32'h0);

    set_ch(0, 2, 1);
    en[0] = 1'b1; co = '0; ct = '0;
    cap(6, 0);
    chk("basic_out", co, 32'b100100);
    chk("basic_tick", ct, 32'b100100);

    restart_ch0(3, 0);
    cap(8, 0);
    chk("hi0_out", co, 32'h0);
    chk("hi0_tick", ct, 32'b10001000);

    restart_ch0(3, 4);
    cap(8, 0);
    chk("hibig_out", co, 32'hFF);

    restart_ch0(0, 1);
    cap(6, 0);
    chk("div0_out", co, 32'h3F);
    chk("div0_tick", ct, 32'h3F);

    restart_ch0(4, 2);
    cap(2, 0);
    set_ch(0, 1, 1);
    cap(7, 0);
    chk("reload_out", co, 32'b110001010);
    chk("reload_tick", ct, 32'b100001010);

    en = '0;
    @(negedge clk);
    set_ch(0, 2, 1); set_ch(1, 4, 2);
    en = 2'b01;
    @(negedge clk);
    en = 2'b11;
    repeat (3) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_tick", 32'(tick_o), 32'h3);
    first = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (tick_o == 2'b11 && first == 0) first = j;
    end
    chk("sync_coincide", 32'(first), 32'd15);

    en = '0;
    @(negedge clk);
    set_ch(0, 1, 1); set_ch(1, 2, 2);
    en = 2'b11;
    co = '0; dis_out = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      co = {co[30:0], out_o[0]};
      if (j >= 4 && j <= 7) dis_out = {dis_out[2:0], out_o[1] | tick_o[1]};
      if (j == 8) begin
        chk("restart_tick1", 32'(tick_o[1]), 32'h1);
        chk("restart_out1", 32'(out_o[1]), 32'h1);
      end
      if (j == 3) en[1] = 1'b0;
      if (j == 7) en[1] = 1'b1;
    end
    chk("indep_out0", co, 32'hAAA);
    chk("disabled_ch1", 32'(dis_out), 32'h0);

    restart_ch0(3, 2);
    en[1] = 1'b0;
    @(negedge clk);
    chk("pre_reset_out", 32'(out_o[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_o), 32'h0);
    chk("async_rst_tick", 32'(tick_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
